// File: rtl/mem_if_pkg.sv
// Shared constants and state encoding for the data-memory burst master.
package mem_if_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 16;
  localparam int LEN_W    = 4;
  localparam int READ_LAT = 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    WR_ISSUE,
    RD_ISSUE,
    RD_HOLD,
    DONE
  } burst_state_e;

endpackage

// File: rtl/mem_burst_addr_gen.sv
// Burst address/length tracker: loads a start address and word count,
// then steps the address (wrapping) and reports the last word.
module mem_burst_addr_gen #(
  parameter int ADDR_W = mem_if_pkg::ADDR_W,
  parameter int LEN_W  = mem_if_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              step,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              last
);

  logic [LEN_W-1:0] remaining;

  // remaining counts words still to go after the current one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= '0;
      remaining <= '0;
    end else if (load) begin
      cur_addr  <= load_addr;
      remaining <= load_len;
    end else if (step) begin
      cur_addr <= cur_addr + ADDR_W'(1);
      if (!last) begin
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

  assign last = (remaining == '0);

endmodule

// File: rtl/mem_burst_master.sv
// Burst load/store initiator for the 16-bit data memory: turns burst commands
// into per-word memRead/memWrite cycles with valid/ready data streams.
module mem_burst_master #(
  parameter int DATA_W   = mem_if_pkg::DATA_W,
  parameter int ADDR_W   = mem_if_pkg::ADDR_W,
  parameter int LEN_W    = mem_if_pkg::LEN_W,
  parameter int READ_LAT = mem_if_pkg::READ_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              memRead,
  output logic              memWrite,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  import mem_if_pkg::*;

  localparam int LAT_W = 3;

  burst_state_e      state_q, state_d;
  logic [LAT_W-1:0]  lat_cnt_q;
  logic              lat_done;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [DATA_W-1:0] wdata_hold_q;
  logic              ag_load;
  logic              ag_step;
  logic [ADDR_W-1:0] cur_addr;
  logic              last;

  mem_burst_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ag_load),
    .load_addr (cmd_addr),
    .load_len  (cmd_len),
    .step      (ag_step),
    .cur_addr  (cur_addr),
    .last      (last)
  );

  assign lat_done = (lat_cnt_q == LAT_W'(READ_LAT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ag_load = 1'b0;
    ag_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          ag_load = 1'b1;
          state_d = cmd_write ? WR_WAIT : RD_ISSUE;
        end
      end
      WR_WAIT: begin
        if (wdata_valid) begin
          state_d = WR_ISSUE;
        end
      end
      WR_ISSUE: begin
        ag_step = 1'b1;
        state_d = last ? DONE : WR_WAIT;
      end
      RD_ISSUE: begin
        if (lat_done) begin
          state_d = RD_HOLD;
        end
      end
      RD_HOLD: begin
        if (rdata_ready) begin
          if (last) begin
            state_d = DONE;
          end else begin
            ag_step = 1'b1;
            state_d = RD_ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Data/latency registers; the hold copies keep the memory port static
  // between issue cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt_q    <= '0;
      wr_data_q    <= '0;
      rd_data_q    <= '0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
    end else begin
      if (state_q == RD_ISSUE && !lat_done) begin
        lat_cnt_q <= lat_cnt_q + LAT_W'(1);
      end else begin
        lat_cnt_q <= '0;
      end
      if (state_q == WR_WAIT && wdata_valid) begin
        wr_data_q <= wdata;
      end
      if (state_q == RD_ISSUE && lat_done) begin
        rd_data_q <= read_data;
      end
      if (state_q == WR_ISSUE || state_q == RD_ISSUE) begin
        addr_hold_q <= cur_addr;
      end
      if (state_q == WR_ISSUE) begin
        wdata_hold_q <= wr_data_q;
      end
    end
  end

  // cmd_ready is gated by rst_n so it stays low while reset is held
  assign cmd_ready   = rst_n && (state_q == IDLE);
  assign wdata_ready = (state_q == WR_WAIT);
  assign rdata_valid = (state_q == RD_HOLD);
  assign rdata       = rd_data_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign memWrite    = (state_q == WR_ISSUE);
  assign memRead     = (state_q == RD_ISSUE);
  assign address     = (memWrite || memRead) ? cur_addr : addr_hold_q;
  assign write_data  = memWrite ? wr_data_q : wdata_hold_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed and randomized bench for mem_burst_master against a word-array
// memory and an expected-contents model.
module tb_mem_burst_master;

  localparam int READ_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [15:0] wdata = '0;
  logic        rdata_valid;
  logic        rdata_ready = 1'b0;
  logic [15:0] rdata;
  logic        busy;
  logic        done;
  logic        memRead;
  logic        memWrite;
  logic [15:0] address;
  logic [15:0] write_data;
  logic [15:0] read_data;

  logic [15:0] mem [0:65535];
  logic        written [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [15:0] wq [$];
  int          wr_count = 0;
  int          done_count = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  mem_burst_master #(.READ_LAT(READ_LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .rdata_valid (rdata_valid),
    .rdata_ready (rdata_ready),
    .rdata       (rdata),
    .busy        (busy),
    .done        (done),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data)
  );

  function automatic logic [15:0] init_word(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // Data memory: untouched words read back their power-on pattern
  assign read_data = written[address] ? mem[address] : init_word(address);

  always @(posedge clk) begin
    if (memWrite) begin
      mem[address]     <= write_data;
      written[address] <= 1'b1;
      wr_count         <= wr_count + 1;
    end
    if (done) begin
      done_count <= done_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue_cmd(input logic wr, input logic [15:0] a, input logic [3:0] l);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = l;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_cmd", busy, 1);
  endtask

  // Store the words in wq starting at a; optionally stall before word gap_at
  // while pulsing a competing command that must be ignored.
  task automatic do_store(input logic [15:0] a, input int gap_at, input int gap_len);
    int          n;
    int          wc0 = wr_count;
    int          dc0 = done_count;
    logic [15:0] ea;
    logic [3:0]  l = 4'(wq.size() - 1);
    issue_cmd(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      ea = 16'(a + i);
      if (i == gap_at) begin
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 16'h1234;
        cmd_len   = 4'd0;
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          check("stall_memWrite", memWrite, 0);
          check("stall_wdata_ready", wdata_ready, 1);
          check("stall_cmd_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
      end
      wdata_valid = 1'b1;
      wdata       = wq[i];
      n = 0;
      while (!wdata_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("wdata_ready_wait", wdata_ready, 1);
      @(negedge clk);
      wdata_valid = 1'b0;
      check("wr_memWrite", memWrite, 1);
      check("wr_excl", memRead, 0);
      check("wr_address", address, ea);
      check("wr_data", write_data, wq[i]);
      ref_mem[ea] = wq[i];
    end
    @(negedge clk);
    check("wr_done", done, 1);
    check("wr_done_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    check("wr_idle_busy", busy, 0);
    check("wr_count", wr_count - wc0, int'(l) + 1);
    check("wr_done_count", done_count - dc0, 1);
  endtask

  // Load len+1 words from a, holding each word unacknowledged for stall cycles.
  task automatic do_load(input logic [15:0] a, input logic [3:0] l, input int stall);
    int          n;
    int          rc;
    int          dc0 = done_count;
    logic [15:0] ea;
    issue_cmd(1'b0, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      ea = 16'(a + i);
      rc = 0;
      n  = 0;
      while (!rdata_valid && n < 50) begin
        if (memRead) begin
          rc++;
          check("rd_address", address, ea);
          check("rd_excl", memWrite, 0);
        end
        @(negedge clk);
        n++;
      end
      check("rd_valid_wait", rdata_valid, 1);
      check("rd_latency", rc, READ_LAT);
      check("rd_data", rdata, ref_mem[ea]);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check("bp_valid", rdata_valid, 1);
        check("bp_data", rdata, ref_mem[ea]);
        check("bp_memRead", memRead, 0);
        check("bp_address", address, ea);
      end
      rdata_ready = 1'b1;
      @(negedge clk);
      rdata_ready = 1'b0;
    end
    check("rd_done", done, 1);
    @(negedge clk);
    check("rd_idle_busy", busy, 0);
    check("rd_done_count", done_count - dc0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ra;
    int          rl;
    int          wc0;
    for (int i = 0; i < 65536; i++) begin
      written[i] = 1'b0;
      ref_mem[i] = init_word(16'(i));
    end

    // Reset held for three cycles
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("reset_ctrl", {cmd_ready, wdata_ready, rdata_valid, busy, done, memRead, memWrite}, 0);
      check("reset_address", address, 0);
      check("reset_write_data", write_data, 0);
      check("reset_rdata", rdata, 0);
    end
    rst_n = 1'b1;
    #1;
    check("post_reset_cmd_ready", cmd_ready, 1);
    check("post_reset_busy", busy, 0);
    check("reset_no_writes", wr_count, 0);
    @(negedge clk);

    // Single-word store then load
    wq = {16'd15};
    do_store(16'h0014, -1, 0);
    do_load(16'h0014, 4'd0, 0);

    // Wrapping burst across 0xFFFF
    wq = {16'd1, 16'd2, 16'd3, 16'd4};
    do_store(16'hFFFE, -1, 0);
    do_load(16'hFFFE, 4'd3, 0);

    // Read backpressure
    do_load(16'hFFFE, 4'd3, 5);

    // Store stall with an ignored command pulse
    wq = {};
    for (int i = 0; i < 6; i++) wq.push_back(16'($urandom));
    do_store(16'h0100, 2, 4);
    do_load(16'h0100, 4'd5, 0);

    // Randomized bursts
    for (int k = 0; k < 6; k++) begin
      ra = 16'($urandom);
      rl = int'($urandom_range(0, 15));
      wq = {};
      for (int i = 0; i <= rl; i++) wq.push_back(16'($urandom));
      do_store(ra, int'($urandom_range(1, 16)), int'($urandom_range(1, 3)));
      do_load(ra, 4'(rl), int'($urandom_range(0, 2)));
    end

    // Reset asserted during a write issue cycle
    wc0 = wr_count;
    issue_cmd(1'b1, 16'h0200, 4'd1);
    wdata_valid = 1'b1;
    wdata       = 16'hBEEF;
    rl = 0;
    while (!wdata_ready && rl < 50) begin
      @(negedge clk);
      rl++;
    end
    @(negedge clk);
    wdata_valid = 1'b0;
    check("mid_reset_issue", memWrite, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_reset_memWrite", memWrite, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_cmd_ready", cmd_ready, 0);
    repeat (2) @(negedge clk);
    check("mid_reset_no_write", wr_count - wc0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_reset_recover", cmd_ready, 1);
    do_load(16'h0200, 4'd1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
